sort_pipe: RTL

- Parametrised, fully pipelined odd-even transposition sorting network built from compare-swap cells.
- Accepts NUM_SAMPLES samples per beat and emits them sorted, with dedicated median/min/max outputs.
- Sits between the window generator and the filter output stage; generalises the single compare-swap cell to N inputs with valid/ready flow control.

---
 rtl/sort_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sort_pipe.sv
// sort_pipe: fully pipelined odd-even transposition sorter with registered median/min/max taps.
// Define SORT_PIPE_FULL_OUT_EN to also export the complete final-stage vector on out_sorted.
module sort_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 9,
  parameter bit DESCENDING  = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH*NUM_SAMPLES-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_median,
  output logic [DATA_WIDTH-1:0]               out_min,
  output logic [DATA_WIDTH-1:0]               out_max,
`ifdef SORT_PIPE_FULL_OUT_EN
  output logic [DATA_WIDTH*NUM_SAMPLES-1:0]   out_sorted,
`endif
  output logic                                busy,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]    occupancy
);

  localparam int OccWidth = $clog2(NUM_SAMPLES + 1);
  localparam int Last     = NUM_SAMPLES - 1;
  localparam int Mid      = (NUM_SAMPLES - 1) / 2;

  typedef logic [DATA_WIDTH-1:0] sample_t;

  logic                   stall;
  logic                   accept;
  logic                   drain;
  logic [NUM_SAMPLES-1:0] validQ;
  logic [NUM_SAMPLES-1:0] validD;
  logic [OccWidth-1:0]    occupancyQ;
  logic [OccWidth-1:0]    occupancyD;

  // A stalled head freezes the whole pipe, bubbles included.
  assign stall    = validQ[Last] && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign drain    = validQ[Last] && out_ready;

  for (genvar s = 0; s < NUM_SAMPLES; s++) begin : gStage
    sample_t src [NUM_SAMPLES];
    sample_t d   [NUM_SAMPLES];
    sample_t q   [NUM_SAMPLES];

    if (s == 0) begin : gLoad
      always_comb begin
        for (int i = 0; i < NUM_SAMPLES; i++) src[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : gChain
      always_comb begin
        for (int i = 0; i < NUM_SAMPLES; i++) src[i] = gStage[s-1].q[i];
      end
    end

    // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..; the leftover edge element passes through.
    always_comb begin
      sample_t lo;
      sample_t hi;
      lo = '0;
      hi = '0;
      for (int i = 0; i < NUM_SAMPLES; i++) d[i] = src[i];
      for (int i = s % 2; i + 1 < NUM_SAMPLES; i += 2) begin
        if (src[i] < src[i+1]) begin
          lo = src[i];
          hi = src[i+1];
        end else begin
          lo = src[i+1];
          hi = src[i];
        end
        d[i]   = DESCENDING ? hi : lo;
        d[i+1] = DESCENDING ? lo : hi;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NUM_SAMPLES; i++) q[i] <= '0;
      end else if (!stall) begin
        for (int i = 0; i < NUM_SAMPLES; i++) q[i] <= d[i];
      end
    end
  end

  always_comb begin
    validD     = validQ;
    occupancyD = occupancyQ + OccWidth'(accept) - OccWidth'(drain);
    if (!stall) validD = {validQ[NUM_SAMPLES-2:0], in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ     <= '0;
      occupancyQ <= '0;
    end else begin
      validQ     <= validD;
      occupancyQ <= occupancyD;
    end
  end

  assign out_valid  = validQ[Last];
  assign busy       = (occupancyQ != '0);
  assign occupancy  = occupancyQ;
  assign out_median = gStage[Last].q[Mid];
  assign out_min    = DESCENDING ? gStage[Last].q[Last] : gStage[Last].q[0];
  assign out_max    = DESCENDING ? gStage[Last].q[0]    : gStage[Last].q[Last];

`ifdef SORT_PIPE_FULL_OUT_EN
  for (genvar k = 0; k < NUM_SAMPLES; k++) begin : gSorted
    assign out_sorted[k*DATA_WIDTH +: DATA_WIDTH] = gStage[Last].q[k];
  end
`else
  // Only the median/min/max taps leave the block; unused final-stage lanes may be trimmed.
`endif

endmodule
